seg7_scan_controller: RTL and testbench
=======================================

Name: seg7_scan_controller

Overview:
Time-multiplexed scan controller for the devboard's 4-digit common-anode 7-segment display, driven from the core's debug output (register 31 or a port).
- Latches a 16-bit hex value through a valid/ready handshake into a shadow buffer.
- Commits the buffer only at frame boundaries, so the display never shows a torn value.
- Scans the digits with a programmable slot time and a blanking interval to suppress ghosting.

Parameters:
SLOT_CYCLES, 50000, clock cycles per digit slot (1 kHz slot, 250 Hz frame at 50 MHz); must be >= 2
BLANK_CYCLES, 2500, cycles at the start of each slot with all digits off; BLANK_CYCLES < SLOT_CYCLES is required, otherwise elaboration fails with $error

Ports:
clock  input  1  system clock
notReset  input  1  asynchronous active-low reset
loadData  input  16  hex value; nibble [15:12] goes to digit 0 (leftmost), [3:0] to digit 3
loadDp  input  4  decimal points; bit i lights the DP of digit i; captured with loadData
loadValid  input  1  load request
loadReady  output  1  shadow buffer empty; a load is accepted when loadValid && loadReady
segment  output  8  active-low segments; [0]=a .. [6]=g, [7]=DP
digit  output  4  active-low digit enables; bit i selects digit i
frameStart  output  1  one-cycle pulse on the cycle the active value is committed

Behaviour:
- Clock is `clock`. Reset is asynchronous, active-low, on `notReset`.
- Reset state:
  - segment=8'hFF, digit=4'hF, frameStart=0, loadReady=1
  - slot counter=0, digit index=0, FSM in BLANK
  - active value=16'h0000 with DP=4'h0; pending buffer empty
- FSM:
  - BLANK: held for BLANK_CYCLES cycles, then go to SHOW.
  - SHOW: held for SLOT_CYCLES-BLANK_CYCLES cycles, then go to BLANK with index+1 (mod 4).
  - If BLANK_CYCLES=0, BLANK is skipped entirely.
- Slot counter: counts 0..SLOT_CYCLES-1 and wraps at the end of SHOW. Width is $clog2(SLOT_CYCLES).
- Outputs are registered and assume their new values on the same edge the FSM enters the state:
  - BLANK: digit=4'hF, segment=8'hFF.
  - SHOW: digit has only bit[index] low; segment = decoded nibble, with [7] low iff that digit's DP bit is set.
- Handshake and commit:
  - Accept edge: loadData/loadDp are written into the pending buffer and loadReady goes low on the next cycle.
  - Frame boundary (edge leaving SHOW with index=3):
    - if pending is full, copy it to active, clear pending, and set loadReady=1 from the next cycle;
    - frameStart pulses high for that one cycle whether or not a commit occurred.
  - A load accepted on the frame-boundary edge itself waits for the following boundary.
  - Latency: an accepted value first appears in digit 0's SHOW phase after the next frameStart.
- Reset mid-operation: any pending value is discarded. Outputs return to their reset values immediately (asynchronously).

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined:
  - Digits left of the first nonzero nibble get segment[6:0]=7'h7F (off). Their DP still follows loadDp.
  - Digit 3 is always shown, so 0000 displays a single 0.
  - Suppression is computed from the active value only.
- Undefined: all four digits always show their hex value.

Decomposition:
- Package seg7_pkg:
  - typedef seg_pattern_t (logic [7:0])
  - enum scan_state_t {BLANK, SHOW}
  - constants SEG_OFF=8'hFF and DIGITS_OFF=4'hF
- One sub-module, hex7seg_decoder: combinational, 4-bit nibble in, active-low 7-bit pattern out.
  - Required encodings: 0→C0, 1→F9, 2→A4, 3→B0, 4→99, 5→92, 8→80, A→88, F→8E (bit 7 shown as 1).

Test Plan (SLOT_CYCLES=8, BLANK_CYCLES=2):
- Reset release → digit=F and segment=FF for 2 cycles, then digit=E with segment=C0; loadReady=1; frameStart pulses every 32 cycles.
- loadData=16'h1234 pulsed mid-frame → loadReady=0 next cycle; display stays 0000 until frameStart; then digits 0..3 show F9, A4, B0, 99; loadReady=1.
- Second load presented while loadReady=0 → not accepted; held loadValid is accepted the cycle after frameStart; each value shows for exactly one full frame.
- loadDp=4'b1000 with value 16'h000A → digit 3 segment=08 (DP lit); other digits have bit 7 high.
- notReset asserted during SHOW with a pending value → outputs go to FF/F immediately; after release the display shows 0000 and the pending value is lost.
- With SEG7_LEADING_ZERO_BLANK_EN, value 16'h0050 → digits 0 and 1 segment=FF, digit 2=92, digit 3=C0; value 16'h0000 → only digit 3 shows C0.

Source files
------------

// File: rtl/seg7_scan_controller_pkg.sv
// ----------------------------------------------------------------------------
// seg7_pkg
// Shared types and constants for the 4-digit 7-segment scan controller.
//   seg_pattern_t : active-low segment byte, [0]=a .. [6]=g, [7]=DP
//   scan_state_t  : scan FSM states (BLANK, SHOW)
//   SEG_OFF       : all segments dark
//   DIGITS_OFF    : all digit enables inactive
//   nibble_sel()  : picks the nibble shown on digit i (digit 0 = [15:12])
// ----------------------------------------------------------------------------
package seg7_pkg;

  typedef logic [7:0] seg_pattern_t;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  localparam seg_pattern_t SEG_OFF    = 8'hFF;
  localparam logic [3:0]   DIGITS_OFF = 4'hF;

  // Digit 0 is the leftmost digit and carries the most significant nibble.
  function automatic logic [3:0] nibble_sel(input logic [15:0] value, input logic [1:0] idx);
    logic [3:0] nib;
    case (idx)
      2'd0:    nib = value[15:12];
      2'd1:    nib = value[11:8];
      2'd2:    nib = value[7:4];
      default: nib = value[3:0];
    endcase
    return nib;
  endfunction

endpackage

// File: rtl/seg7_scan_controller_if.sv
// ----------------------------------------------------------------------------
// seg7_scan_controller_if
// Load handshake between the core debug output and the scan controller.
//   loadData  : 16-bit hex value, [15:12] -> digit 0 .. [3:0] -> digit 3
//   loadDp    : decimal points, bit i -> digit i
//   loadValid : load request from the producer
//   loadReady : shadow buffer empty; transfer when loadValid && loadReady
// Modports: master (producer), slave (scan controller).
// ----------------------------------------------------------------------------
interface seg7_scan_controller_if;

  logic [15:0] loadData;
  logic [3:0]  loadDp;
  logic        loadValid;
  logic        loadReady;

  modport master (
    output loadData,
    output loadDp,
    output loadValid,
    input  loadReady
  );

  modport slave (
    input  loadData,
    input  loadDp,
    input  loadValid,
    output loadReady
  );

endinterface

// File: rtl/seg7_scan_controller_decoder.sv
// ----------------------------------------------------------------------------
// hex7seg_decoder
// Combinational hex-to-7-segment decoder for a common-anode display.
//   nibble_i : 4-bit hex digit
//   seg_n_o  : active-low segment pattern, [0]=a .. [6]=g
// ----------------------------------------------------------------------------
module hex7seg_decoder (
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_n_o
);

  // Lookup table of the sixteen hex glyphs.
  always_comb begin
    seg_n_o = 7'h7F;
    case (nibble_i)
      4'h0:    seg_n_o = 7'h40;
      4'h1:    seg_n_o = 7'h79;
      4'h2:    seg_n_o = 7'h24;
      4'h3:    seg_n_o = 7'h30;
      4'h4:    seg_n_o = 7'h19;
      4'h5:    seg_n_o = 7'h12;
      4'h6:    seg_n_o = 7'h02;
      4'h7:    seg_n_o = 7'h78;
      4'h8:    seg_n_o = 7'h00;
      4'h9:    seg_n_o = 7'h10;
      4'hA:    seg_n_o = 7'h08;
      4'hB:    seg_n_o = 7'h03;
      4'hC:    seg_n_o = 7'h46;
      4'hD:    seg_n_o = 7'h21;
      4'hE:    seg_n_o = 7'h06;
      4'hF:    seg_n_o = 7'h0E;
      default: seg_n_o = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seg7_scan_controller.sv
// ----------------------------------------------------------------------------
// seg7_scan_controller
// Time-multiplexed scan of a 4-digit common-anode 7-segment display. A value
// is taken into a shadow buffer over a valid/ready handshake and only becomes
// visible at a frame boundary, so a frame never mixes two values. Every digit
// slot starts with a blanking interval to suppress ghosting.
// Ports:
//   clock      : system clock
//   notReset   : asynchronous active-low reset
//   load       : load handshake (seg7_scan_controller_if.slave)
//   segment    : active-low segments, [0]=a .. [6]=g, [7]=DP (registered)
//   digit      : active-low digit enables, bit i = digit i (registered)
//   frameStart : one-cycle pulse on the cycle the active value is committed
// Parameters: SLOT_CYCLES (>= 2), BLANK_CYCLES (< SLOT_CYCLES).
// Build option: SEG7_LEADING_ZERO_BLANK_EN darkens leading zero digits
// (digit 3 always shown, DP unaffected).
// ----------------------------------------------------------------------------
module seg7_scan_controller
  import seg7_pkg::*;
#(
  parameter int SLOT_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 2500
) (
  input  logic                    clock,
  input  logic                    notReset,
  seg7_scan_controller_if.slave   load,
  output logic [7:0]              segment,
  output logic [3:0]              digit,
  output logic                    frameStart
);

  localparam int CW = $clog2(SLOT_CYCLES);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES - 1) : '0;

  if (SLOT_CYCLES < 2 || BLANK_CYCLES >= SLOT_CYCLES || BLANK_CYCLES < 0) begin : g_param_check
    $error("seg7_scan_controller: need SLOT_CYCLES >= 2 and 0 <= BLANK_CYCLES < SLOT_CYCLES");
  end

  scan_state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]   idx_q, idx_d;
  logic [15:0]  active_val_q, active_val_d;
  logic [3:0]   active_dp_q, active_dp_d;
  logic [15:0]  pend_val_q, pend_val_d;
  logic [3:0]   pend_dp_q, pend_dp_d;
  logic         ready_q, ready_d;
  seg_pattern_t seg_q, seg_d;
  logic [3:0]   dig_q, dig_d;
  logic         fs_q, fs_d;

  logic         slot_end_s;
  logic         frame_end_s;
  logic         accept_s;
  logic         lz_s;
  logic [3:0]   nib_s;
  logic [6:0]   dec_s;

  assign slot_end_s  = (state_q == SHOW) && (cnt_q == SLOT_LAST);
  assign frame_end_s = slot_end_s && (idx_q == 2'd3);
  assign accept_s    = load.loadValid && ready_q;

  // Scan FSM, slot counter, shadow buffer and frame-boundary commit.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CW'(1);
    idx_d        = idx_q;
    active_val_d = active_val_q;
    active_dp_d  = active_dp_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    ready_d      = ready_q;
    fs_d         = frame_end_s;

    case (state_q)
      BLANK: begin
        if (BLANK_CYCLES == 0 || cnt_q == BLANK_LAST) begin
          state_d = SHOW;
        end else begin
          state_d = BLANK;
        end
      end
      SHOW: begin
        if (slot_end_s) begin
          cnt_d   = '0;
          idx_d   = idx_q + 2'd1;
          // With no blanking interval the next slot starts directly in SHOW.
          state_d = (BLANK_CYCLES == 0) ? SHOW : BLANK;
        end else begin
          state_d = SHOW;
        end
      end
      default: begin
        state_d = BLANK;
        cnt_d   = '0;
      end
    endcase

    // Accept only while empty; a full buffer is drained only at the frame
    // boundary, so a load taken on the boundary edge waits one more frame.
    if (accept_s) begin
      pend_val_d = load.loadData;
      pend_dp_d  = load.loadDp;
      ready_d    = 1'b0;
    end else if (frame_end_s && !ready_q) begin
      active_val_d = pend_val_q;
      active_dp_d  = pend_dp_q;
      ready_d      = 1'b1;
    end else begin
      ready_d = ready_q;
    end
  end

  // Outputs are computed from the next state so they change on the entry edge.
  assign nib_s = nibble_sel(active_val_d, idx_d);

  hex7seg_decoder u_dec (
    .nibble_i (nib_s),
    .seg_n_o  (dec_s)
  );

  // Leading-zero suppression looks only at the value about to be displayed.
  always_comb begin
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    case (idx_d)
      2'd0:    lz_s = (active_val_d[15:12] == 4'h0);
      2'd1:    lz_s = (active_val_d[15:8] == 8'h00);
      2'd2:    lz_s = (active_val_d[15:4] == 12'h000);
      default: lz_s = 1'b0;
    endcase
`else
    lz_s = 1'b0;
`endif
  end

  // Next segment/digit drive for the state being entered.
  always_comb begin
    seg_d = SEG_OFF;
    dig_d = DIGITS_OFF;
    if (state_d == SHOW) begin
      dig_d = ~(4'b0001 << idx_d);
      seg_d = {~active_dp_d[idx_d], (lz_s ? 7'h7F : dec_s)};
    end else begin
      dig_d = DIGITS_OFF;
      seg_d = SEG_OFF;
    end
  end

  // State and output registers; reset discards any pending value.
  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      state_q      <= BLANK;
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      active_val_q <= 16'h0000;
      active_dp_q  <= 4'h0;
      pend_val_q   <= 16'h0000;
      pend_dp_q    <= 4'h0;
      ready_q      <= 1'b1;
      seg_q        <= SEG_OFF;
      dig_q        <= DIGITS_OFF;
      fs_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      active_val_q <= active_val_d;
      active_dp_q  <= active_dp_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      ready_q      <= ready_d;
      seg_q        <= seg_d;
      dig_q        <= dig_d;
      fs_q         <= fs_d;
    end
  end

  assign segment        = seg_q;
  assign digit          = dig_q;
  assign frameStart     = fs_q;
  assign load.loadReady = ready_q;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// ----------------------------------------------------------------------------
// tb_seg7_scan_controller
// Directed bench for seg7_scan_controller with SLOT_CYCLES=8, BLANK_CYCLES=2
// (32-cycle frames). Expected digit/segment pairs for a frame are queued when
// the load that produces them is driven and popped while the frame scans.
// Honours SEG7_LEADING_ZERO_BLANK_EN in its reference model.
// ----------------------------------------------------------------------------
module tb_seg7_scan_controller;

  typedef struct packed {
    logic [3:0] dig;
    logic [7:0] seg;
  } exp_t;

  logic       clock;
  logic       notReset;
  logic [7:0] segment;
  logic [3:0] digit;
  logic       frameStart;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   prev_fs_cyc = 0;
  bit   have_prev = 1'b0;
  exp_t sb[$];

  seg7_scan_controller_if lif ();

  seg7_scan_controller #(
    .SLOT_CYCLES  (8),
    .BLANK_CYCLES (2)
  ) dut (
    .clock      (clock),
    .notReset   (notReset),
    .load       (lif),
    .segment    (segment),
    .digit      (digit),
    .frameStart (frameStart)
  );

  // 10 ns clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Free-running cycle count used to measure the frame period.
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'h40; 4'h1: g = 7'h79; 4'h2: g = 7'h24; 4'h3: g = 7'h30;
      4'h4: g = 7'h19; 4'h5: g = 7'h12; 4'h6: g = 7'h02; 4'h7: g = 7'h78;
      4'h8: g = 7'h00; 4'h9: g = 7'h10; 4'hA: g = 7'h08; 4'hB: g = 7'h03;
      4'hC: g = 7'h46; 4'hD: g = 7'h21; 4'hE: g = 7'h06; default: g = 7'h0E;
    endcase
    return g;
  endfunction

  function automatic logic [7:0] exp_seg(input logic [15:0] v, input logic [3:0] dp, input int i);
    logic [3:0]  n;
    logic [15:0] lead;
    logic        lz;
    n    = v[15 - 4*i -: 4];
    lead = v >> (12 - 4*i);
    lz   = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (i < 3 && lead == 16'h0000) lz = 1'b1;
`endif
    return {~dp[i], (lz ? 7'h7F : glyph(n))};
  endfunction

  function automatic logic [3:0] exp_dig(input int i);
    logic [3:0] tbl [4];
    tbl[0] = 4'hE; tbl[1] = 4'hD; tbl[2] = 4'hB; tbl[3] = 4'h7;
    return tbl[i];
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [15:0] v, input logic [3:0] dp);
    for (int i = 0; i < 4; i++) sb.push_back('{dig: exp_dig(i), seg: exp_seg(v, dp, i)});
  endtask

  // Bounded wait for the next frameStart; also checks the frame period.
  task automatic wait_frame(input string tag);
    int n = 0;
    while (frameStart !== 1'b1 && n < 64) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_seen"}, {15'd0, frameStart}, 16'd1);
    if (have_prev) chk({tag, "_period"}, 16'(cyc - prev_fs_cyc), 16'd32);
    prev_fs_cyc = cyc;
    have_prev   = 1'b1;
  endtask

  // Called on the frameStart cycle; ends during digit 3's SHOW phase.
  task automatic check_frame(input string tag, input logic exp_ready_n1);
    exp_t e;
    chk({tag, "_blank_dig"}, {12'd0, digit}, 16'h000F);
    chk({tag, "_blank_seg"}, {8'd0, segment}, 16'h00FF);
    chk({tag, "_ready_fs"}, {15'd0, lif.loadReady}, 16'd1);
    @(negedge clock);
    chk({tag, "_fs_pulse"}, {15'd0, frameStart}, 16'd0);
    chk({tag, "_ready_n1"}, {15'd0, lif.loadReady}, {15'd0, exp_ready_n1});
    lif.loadValid = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      if (sb.size() == 0) begin
        chk({tag, "_sb_empty"}, 16'(sb.size()), 16'd1);
      end else begin
        e = sb.pop_front();
        chk($sformatf("%s_dig%0d", tag, i), {12'd0, digit}, {12'd0, e.dig});
        chk($sformatf("%s_seg%0d", tag, i), {8'd0, segment}, {8'd0, e.seg});
      end
      if (i < 3) repeat (8) @(negedge clock);
    end
  endtask

  // Pulse a one-cycle load during digit 3's SHOW phase.
  task automatic pulse_load(input string tag, input logic [15:0] v, input logic [3:0] dp);
    lif.loadData  = v;
    lif.loadDp    = dp;
    lif.loadValid = 1'b1;
    @(negedge clock);
    lif.loadValid = 1'b0;
    chk({tag, "_ready_low"}, {15'd0, lif.loadReady}, 16'd0);
  endtask

  initial begin
    notReset      = 1'b0;
    lif.loadData  = 16'h0000;
    lif.loadDp    = 4'h0;
    lif.loadValid = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_dig", {12'd0, digit}, 16'h000F);
    chk("rst_seg", {8'd0, segment}, 16'h00FF);
    chk("rst_fs", {15'd0, frameStart}, 16'd0);
    chk("rst_ready", {15'd0, lif.loadReady}, 16'd1);

    notReset = 1'b1;
    @(negedge clock);
    chk("rel_blank_dig", {12'd0, digit}, 16'h000F);
    @(negedge clock);
    chk("rel_show_dig", {12'd0, digit}, 16'h000E);
    chk("rel_show_seg", {8'd0, segment}, {8'd0, exp_seg(16'h0000, 4'h0, 0)});

    push_frame(16'h0000, 4'h0);
    wait_frame("f0");
    check_frame("f0", 1'b1);

    // Mid-frame load stays invisible until the boundary.
    pulse_load("ld1234", 16'h1234, 4'h0);
    chk("ld1234_old_dig3", {12'd0, digit}, 16'h0007);
    chk("ld1234_old_seg3", {8'd0, segment}, {8'd0, exp_seg(16'h0000, 4'h0, 3)});
    push_frame(16'h1234, 4'h0);
    wait_frame("f1");
    check_frame("f1", 1'b1);

    // 000A with DP on digit 3; a second value is held while the buffer is full.
    lif.loadData  = 16'h000A;
    lif.loadDp    = 4'b1000;
    lif.loadValid = 1'b1;
    @(negedge clock);
    chk("ld000A_ready_low", {15'd0, lif.loadReady}, 16'd0);
    lif.loadData = 16'h0050;
    lif.loadDp   = 4'h0;
    push_frame(16'h000A, 4'b1000);
    wait_frame("f2");
    check_frame("f2", 1'b0);
    push_frame(16'h0050, 4'h0);
    wait_frame("f3");
    check_frame("f3", 1'b1);

    pulse_load("ld0000", 16'h0000, 4'h0);
    push_frame(16'h0000, 4'h0);
    wait_frame("f4");
    check_frame("f4", 1'b1);

    pulse_load("ldF8A3", 16'hF8A3, 4'b0101);
    push_frame(16'hF8A3, 4'b0101);
    wait_frame("f5");
    check_frame("f5", 1'b1);

    // Reset during SHOW with a pending value.
    pulse_load("ldlost", 16'h1234, 4'hF);
    #1 notReset = 1'b0;
    #1;
    chk("midrst_dig", {12'd0, digit}, 16'h000F);
    chk("midrst_seg", {8'd0, segment}, 16'h00FF);
    chk("midrst_ready", {15'd0, lif.loadReady}, 16'd1);
    chk("midrst_fs", {15'd0, frameStart}, 16'd0);
    repeat (2) @(negedge clock);
    notReset  = 1'b1;
    have_prev = 1'b0;
    @(negedge clock);
    chk("rel2_blank_dig", {12'd0, digit}, 16'h000F);
    @(negedge clock);
    chk("rel2_show_dig", {12'd0, digit}, 16'h000E);
    chk("rel2_show_seg", {8'd0, segment}, {8'd0, exp_seg(16'h0000, 4'h0, 0)});
    push_frame(16'h0000, 4'h0);
    wait_frame("f6");
    check_frame("f6", 1'b1);
    chk("sb_drained", 16'(sb.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
